full_adder_32bit: RTL and testbench
===================================

// Module: full_adder_32bit
// PURPOSE
//   32-bit binary adder with carry-in, carry-out and signed-overflow flag.
//   Combinational result path, plus a registered copy of the result for
//   pipelined consumers. General-purpose arithmetic leaf block used by
//   ALU/datapath modules.
//   Structure: eight 4-bit carry-lookahead groups (bit generate/propagate,
//   group G/P) with the group carries rippled between groups.
// PARAMETERS
//   none (width fixed at 32)
// PORTS
//   clk_i     in   1   clock; rising edge samples the registered outputs
//   rst_ni    in   1   asynchronous, active-low reset
//   A_i       in   32  operand A, unsigned or two's complement
//   Y_i       in   32  operand B, unsigned or two's complement
//   C_i       in   1   carry-in, weight 2^0
//   Sum_o     out  32  combinational sum, (A_i + Y_i + C_i) mod 2^32
//   c_o       out  1   combinational carry-out, bit 32 of the full sum
//   ovf_o     out  1   combinational signed overflow
//   Sum_q_o   out  32  registered Sum_o
//   c_q_o     out  1   registered c_o
//   ovf_q_o   out  1   registered ovf_o
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Combinational path:
//   - {c_o, Sum_o} = A_i + Y_i + C_i, evaluated as a 33-bit unsigned sum.
//   - No clock dependency, zero-cycle latency. The path settles within one
//     propagation delay of any input change.
//   - The path is independent of rst_ni and stays live during reset.
//   - c_o is the true unsigned carry. It is never the overflow flag.
//   - ovf_o = (A_i[31] == Y_i[31]) && (Sum_o[31] != A_i[31]).
//   Carry-lookahead structure, bit i:
//   - g = A&Y, p = A^Y.
//   - Sum[i] = p[i] ^ carry[i].
//   - carry[0] = C_i; c_o = carry[32].
//   Registered path:
//   - On each rising clk_i edge: Sum_q_o <= Sum_o, c_q_o <= c_o,
//     ovf_q_o <= ovf_o. Latency is 1 cycle; there is no enable and no
//     handshake.
//   - rst_ni low forces Sum_q_o = 0, c_q_o = 0, ovf_q_o = 0 immediately
//     (asynchronous). The values hold until the first rising edge after
//     rst_ni returns high.
//   - Reset released mid-stream: the first captured value is the
//     combinational result present at that edge.
//   Boundaries:
//   - Wrap-around: the sum is modulo 2^32 and the carry appears only on c_o.
//   - 0xFFFFFFFF + 0 + 1 gives Sum 0, c_o 1.
//   - 0 + 0 + 0 gives all outputs 0.
//   - Inputs are pure 0/1. X/Z on inputs is not required to be handled.
// TESTING
//   1. A=00000000 Y=00000000 C=0 -> Sum=00000000 c_o=0 ovf=0.
//   2. A=0000000F Y=00000001 C=0 -> Sum=00000010 c_o=0 (carry crosses a group).
//   3. A=FFFFFFF0 Y=00000010 C=0 -> Sum=00000000 c_o=1 ovf=0.
//      A=FFFFFFFF Y=00000001 C=0 -> Sum=00000000 c_o=1.
//   4. A=7FFFFFFF Y=00000001 C=0 -> Sum=80000000 c_o=0 ovf=1.
//      A=80000000 Y=FFFFFFFF C=0 -> Sum=7FFFFFFF c_o=1 ovf=1.
//   5. A=AAAAAAAA Y=55555555 C=0 -> Sum=FFFFFFFF c_o=0 (full propagate chain).
//      Same operands with C=1 -> Sum=00000000 c_o=1.
//      A=12345678 Y=12345678 -> Sum=2468ACF0.
//      A=FFFFFFFE Y=00000002 C=1 -> Sum=00000001 c_o=1.
//   6. Registered path:
//      - Hold rst_ni=0 -> *_q_o all 0 regardless of inputs.
//      - Release reset, apply case 3 -> after 1 edge Sum_q_o=0, c_q_o=1.
//      - Assert rst_ni between edges -> *_q_o clear at once.
//   Plus: 10k random A/Y/C vectors checked against a 33-bit reference sum.

Source files
------------

// File: rtl/full_adder_32bit.sv
// full_adder_32bit: 32-bit carry-lookahead adder with carry/overflow flags and a registered copy of the result
module full_adder_32bit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] A_i,
  input  logic [31:0] Y_i,
  input  logic        C_i,
  output logic [31:0] Sum_o,
  output logic        c_o,
  output logic        ovf_o,
  output logic [31:0] Sum_q_o,
  output logic        c_q_o,
  output logic        ovf_q_o
);
  logic [31:0] g, p, c;
  logic [7:0]  gg, gp;
  logic [8:0]  gc;
  logic [31:0] sum_d, sum_q;
  logic        c_d, c_q, ovf_d, ovf_q;
  assign g = A_i & Y_i;
  assign p = A_i ^ Y_i;
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = C_i;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end
  assign Sum_o = p ^ c;
  assign c_o   = gc[8];
  assign ovf_o = (A_i[31] == Y_i[31]) && (Sum_o[31] != A_i[31]);
  always_comb begin
    sum_d = Sum_o;
    c_d   = c_o;
    ovf_d = ovf_o;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end
  assign Sum_q_o = sum_q;
  assign c_q_o   = c_q;
  assign ovf_q_o = ovf_q;
endmodule

// File: tb/tb_full_adder_32bit.sv
// tb_full_adder_32bit: directed and random checks of full_adder_32bit against an arithmetic reference
module tb_full_adder_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, y = '0, sum, sum_q;
  logic        ci = 1'b0, co, ovf, co_q, ovf_q;
  logic [31:0] exp_s;
  logic        exp_c, exp_v;
  int          checks = 0, failures = 0;

  full_adder_32bit dut (
    .clk_i(clk), .rst_ni(rst_n), .A_i(a), .Y_i(y), .C_i(ci),
    .Sum_o(sum), .c_o(co), .ovf_o(ovf),
    .Sum_q_o(sum_q), .c_q_o(co_q), .ovf_q_o(ovf_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] ai, input logic [31:0] yi, input logic cin);
    logic [32:0] u;
    longint      s;
    u = {1'b0, ai} + {1'b0, yi} + {32'd0, cin};
    s = longint'($signed(ai)) + longint'($signed(yi)) + longint'(cin);
    exp_s = u[31:0];
    exp_c = u[32];
    exp_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic vec(input string tag, input logic [31:0] ai, input logic [31:0] yi, input logic cin);
    a = ai; y = yi; ci = cin;
    model(ai, yi, cin);
    #1;
    chk({tag, ".sum"}, sum, exp_s);
    chk({tag, ".c"}, 32'(co), 32'(exp_c));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_v));
  endtask

  task automatic chk_q(input string tag, input logic [31:0] es, input logic ec, input logic ev);
    chk({tag, ".sum_q"}, sum_q, es);
    chk({tag, ".c_q"}, 32'(co_q), 32'(ec));
    chk({tag, ".ovf_q"}, 32'(ovf_q), 32'(ev));
  endtask

  initial begin
    // combinational path exercised while reset is held low
    @(negedge clk);
    vec("zero", 32'h0, 32'h0, 1'b0);
    chk("zero.lit", sum, 32'h0);
    vec("grp", 32'h0000000F, 32'h1, 1'b0);
    chk("grp.lit", sum, 32'h00000010);
    vec("wrap1", 32'hFFFFFFF0, 32'h10, 1'b0);
    vec("wrap2", 32'hFFFFFFFF, 32'h1, 1'b0);
    chk("wrap2.c_lit", 32'(co), 32'd1);
    vec("ovfp", 32'h7FFFFFFF, 32'h1, 1'b0);
    chk("ovfp.lit", 32'(ovf), 32'd1);
    vec("ovfn", 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("ovfn.lit", sum, 32'h7FFFFFFF);
    vec("prop0", 32'hAAAAAAAA, 32'h55555555, 1'b0);
    vec("prop1", 32'hAAAAAAAA, 32'h55555555, 1'b1);
    chk("prop1.lit", sum, 32'h0);
    vec("dbl", 32'h12345678, 32'h12345678, 1'b0);
    chk("dbl.lit", sum, 32'h2468ACF0);
    vec("cin", 32'hFFFFFFFE, 32'h2, 1'b1);
    vec("cinmax", 32'hFFFFFFFF, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk_q("rst_hold", 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_q("rst_hold2", 32'h0, 1'b0, 1'b0);
    // release reset, first edge captures the live result
    @(negedge clk);
    rst_n = 1'b1;
    vec("rel", 32'hFFFFFFF0, 32'h10, 1'b0);
    @(posedge clk); #1;
    chk_q("rel", 32'h0, 1'b1, 1'b0);
    // asynchronous clear between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_q("async", 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_q("async_hold", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      vec("rnd", $urandom, $urandom, 1'($urandom_range(1)));
      @(posedge clk); #1;
      chk_q("rnd", exp_s, exp_c, exp_v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
